// File: rtl/operand_fetch_pkg.sv
// Shared CPU definitions: datapath sizing, operand-B select codes, ALU control codes
// and the operand-fetch output-register states.
package operand_fetch_pkg;
  localparam int DATA_W = 32;
  localparam int REG_N  = 32;
  localparam int ADDR_W = $clog2(REG_N);

  typedef enum logic [2:0] {
    BSEL_RT    = 3'b000,
    BSEL_SIMM  = 3'b001,
    BSEL_ZIMM  = 3'b010,
    BSEL_LUI   = 3'b011,
    BSEL_SHAMT = 3'b100,
    BSEL_RS    = 3'b101
  } b_sel_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SLL = 4'd3,
    ALU_SRL = 4'd4,
    ALU_SRA = 4'd5,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_XOR = 4'd8,
    ALU_NOR = 4'd12
  } alu_ctl_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } of_state_e;
endpackage

// File: rtl/operand_fetch_regfile_2r1w.sv
// Two-read / one-write register file with r0 hard-wired to zero and
// same-cycle write-to-read forwarding; overflowed write-backs are dropped.
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  localparam int ADDR_W = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_ovf
);
  logic [DATA_W-1:0] mem_r [REG_N];
  logic              we_s;

  assign we_s = wb_valid & ~wb_ovf & (wb_addr != {ADDR_W{1'b0}});

  // Register array: cleared by reset, written when a write-back commits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we_s) begin
      mem_r[wb_addr] <= wb_data;
    end else begin
      mem_r[wb_addr] <= mem_r[wb_addr];
    end
  end

  // Read port A with r0 zeroing and bypass of the committing write
  always_comb begin
    ra_data = {DATA_W{1'b0}};
    if (ra_addr == {ADDR_W{1'b0}}) begin
      ra_data = {DATA_W{1'b0}};
    end else if (we_s && (wb_addr == ra_addr)) begin
      ra_data = wb_data;
    end else begin
      ra_data = mem_r[ra_addr];
    end
  end

  // Read port B with r0 zeroing and bypass of the committing write
  always_comb begin
    rb_data = {DATA_W{1'b0}};
    if (rb_addr == {ADDR_W{1'b0}}) begin
      rb_data = {DATA_W{1'b0}};
    end else if (we_s && (wb_addr == rb_addr)) begin
      rb_data = wb_data;
    end else begin
      rb_data = mem_r[rb_addr];
    end
  end
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, selects ALU operands and holds
// them in a one-entry valid/ready output register.
module operand_fetch #(
  parameter int DATA_W = operand_fetch_pkg::DATA_W,
  parameter int REG_N  = operand_fetch_pkg::REG_N,
  localparam int ADDR_W = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [15:0]       imm16,
  input  logic [4:0]        shamt,
  input  logic              a_sel,
  input  logic [2:0]        b_sel,
  input  logic [3:0]        ctl_in,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_ovf,
  output logic [DATA_W-1:0] ALU_DA,
  output logic [DATA_W-1:0] ALU_DB,
  output logic [3:0]        ALU_CTL,
  output logic              out_valid,
  input  logic              out_ready
);
  import operand_fetch_pkg::*;

  of_state_e         state_r, state_nx_s;
  logic [DATA_W-1:0] rs_val_s, rt_val_s, opa_s, opb_s;
  logic              cap_s;

  regfile_2r1w #(.DATA_W(DATA_W), .REG_N(REG_N)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (rs_addr),
    .rb_addr (rt_addr),
    .ra_data (rs_val_s),
    .rb_data (rt_val_s),
    .wb_valid(wb_valid),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .wb_ovf  (wb_ovf)
  );

  assign out_valid = (state_r == ST_FULL);
  assign in_ready  = ~out_valid | out_ready;
  assign cap_s     = in_valid & in_ready;

  // Output-register occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next occupancy: a capture always refills, otherwise out_ready drains
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (cap_s) state_nx_s = ST_FULL;
        else       state_nx_s = ST_EMPTY;
      end
      ST_FULL: begin
        if (cap_s)          state_nx_s = ST_FULL;
        else if (out_ready) state_nx_s = ST_EMPTY;
        else                state_nx_s = ST_FULL;
      end
      default: state_nx_s = ST_EMPTY;
    endcase
  end

  // Operand selection; shifts take the shifted value from rt on port A
  always_comb begin
    opa_s = {DATA_W{1'b0}};
    if (a_sel) opa_s = rt_val_s;
    else       opa_s = rs_val_s;

    opb_s = {DATA_W{1'b0}};
    case (b_sel)
      BSEL_RT:    opb_s = rt_val_s;
      BSEL_SIMM:  opb_s = {{(DATA_W-16){imm16[15]}}, imm16};
      BSEL_ZIMM:  opb_s = {{(DATA_W-16){1'b0}}, imm16};
      BSEL_LUI:   opb_s = {{(DATA_W-16){1'b0}}, imm16} << 16;
      BSEL_SHAMT: opb_s = {{(DATA_W-5){1'b0}}, shamt};
      BSEL_RS:    opb_s = rs_val_s;
      default:    opb_s = {DATA_W{1'b0}};
    endcase
  end

  // Operand/control capture on handshake; held otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ALU_DA  <= {DATA_W{1'b0}};
      ALU_DB  <= {DATA_W{1'b0}};
      ALU_CTL <= 4'd0;
    end else if (cap_s) begin
      ALU_DA  <= opa_s;
      ALU_DB  <= opb_s;
      ALU_CTL <= ctl_in;
    end else begin
      ALU_DA  <= ALU_DA;
      ALU_DB  <= ALU_DB;
      ALU_CTL <= ALU_CTL;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Randomised bench for operand_fetch: directed scenarios followed by random
// traffic, all checked against a behavioural register/pipeline model.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, a_sel, wb_valid, wb_ovf, out_valid, out_ready;
  logic [4:0]  rs_addr, rt_addr, shamt, wb_addr;
  logic [15:0] imm16;
  logic [2:0]  b_sel;
  logic [3:0]  ctl_in, ALU_CTL;
  logic [31:0] wb_data, ALU_DA, ALU_DB;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_da, m_db;
  logic [3:0]  m_ctl;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .imm16(imm16), .shamt(shamt),
    .a_sel(a_sel), .b_sel(b_sel), .ctl_in(ctl_in), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_ovf(wb_ovf), .ALU_DA(ALU_DA),
    .ALU_DB(ALU_DB), .ALU_CTL(ALU_CTL), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Architectural register value as seen this cycle, including a committing write-back
  function automatic logic [31:0] rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_valid && !wb_ovf && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] op_b();
    case (b_sel)
      3'd0:    return rd(rt_addr);
      3'd1:    return imm16[15] ? 32'hFFFF_0000 + 32'(imm16) : 32'(imm16);
      3'd2:    return 32'(imm16);
      3'd3:    return 32'(imm16) * 32'd65536;
      3'd4:    return 32'(shamt);
      3'd5:    return rd(rs_addr);
      default: return 32'd0;
    endcase
  endfunction

  task automatic idle();
    in_valid = 1'b0; rs_addr = 5'd0; rt_addr = 5'd0; imm16 = 16'd0; shamt = 5'd0;
    a_sel = 1'b0; b_sel = 3'd0; ctl_in = 4'd0; wb_valid = 1'b0; wb_addr = 5'd0;
    wb_data = 32'd0; wb_ovf = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
  endtask

  // Entered at a falling edge with inputs applied; checks, then advances one cycle
  task automatic tick();
    logic        n_valid;
    logic [31:0] n_da, n_db;
    logic [3:0]  n_ctl;
    logic        cap, wr;
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    check("alu_da", ALU_DA, m_da);
    check("alu_db", ALU_DB, m_db);
    check("alu_ctl", 32'(ALU_CTL), 32'(m_ctl));
    cap = in_valid && (!m_valid || out_ready);
    wr  = wb_valid && !wb_ovf && wb_addr != 5'd0;
    n_valid = cap ? 1'b1 : (out_ready ? 1'b0 : m_valid);
    n_da  = cap ? (a_sel ? rd(rt_addr) : rd(rs_addr)) : m_da;
    n_db  = cap ? op_b() : m_db;
    n_ctl = cap ? ctl_in : m_ctl;
    @(posedge clk);
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_valid = 1'b0; m_da = 32'd0; m_db = 32'd0; m_ctl = 4'd0;
    end else begin
      if (wr) m_regs[wb_addr] = wb_data;
      m_valid = n_valid; m_da = n_da; m_db = n_db; m_ctl = n_ctl;
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic asel,
                       input logic [2:0] bsel, input logic [15:0] imm, input logic [4:0] sh);
    in_valid = 1'b1; rs_addr = rs; rt_addr = rt; a_sel = asel; b_sel = bsel;
    imm16 = imm; shamt = sh; ctl_in = 4'($urandom_range(0, 15));
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d, input logic ovf);
    wb_valid = 1'b1; wb_addr = a; wb_data = d; wb_ovf = ovf;
  endtask

  initial begin
    logic [31:0] held;
    foreach (m_regs[i]) m_regs[i] = 32'hX;
    m_valid = 1'bx; m_da = 32'hX; m_db = 32'hX; m_ctl = 4'hX;
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    foreach (m_regs[i]) m_regs[i] = 32'd0;
    m_valid = 1'b0; m_da = 32'd0; m_db = 32'd0; m_ctl = 4'd0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);

    // write then read with sign-extended immediate
    wb(5'd5, 32'h0000_1234, 1'b0); tick(); idle();
    issue(5'd5, 5'd0, 1'b0, 3'b001, 16'hFFFE, 5'd0); tick(); idle();
    check("wr_rd_da", ALU_DA, 32'h0000_1234);
    check("wr_rd_db", ALU_DB, 32'hFFFF_FFFE);
    check("wr_rd_valid", 32'(out_valid), 32'd1);

    // r0 ignores writes, overflowed write-back is dropped
    wb(5'd0, 32'hDEAD_BEEF, 1'b0); tick();
    wb(5'd7, 32'h8000_0000, 1'b1); tick(); idle();
    issue(5'd0, 5'd7, 1'b0, 3'b000, 16'd0, 5'd0); tick(); idle();
    check("r0_zero", ALU_DA, 32'd0);
    check("ovf_drop", ALU_DB, 32'd0);

    // same-cycle forwarding
    wb(5'd3, 32'h55, 1'b0); issue(5'd0, 5'd3, 1'b0, 3'b000, 16'd0, 5'd0); tick(); idle();
    check("fwd_db", ALU_DB, 32'h55);

    // backpressure: hold for three cycles, then refill without a bubble
    issue(5'd5, 5'd3, 1'b1, 3'b101, 16'd0, 5'd0); out_ready = 1'b0; tick();
    held = ALU_DA;
    issue(5'd3, 5'd5, 1'b0, 3'b000, 16'd0, 5'd0); out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    check("stall_hold_da", ALU_DA, held);
    out_ready = 1'b1; tick(); idle();
    check("refill_valid", 32'(out_valid), 32'd1);
    check("refill_da", ALU_DA, 32'h55);

    // immediate forms
    issue(5'd0, 5'd0, 1'b0, 3'b010, 16'h8001, 5'd0); tick();
    check("zimm", ALU_DB, 32'h0000_8001);
    issue(5'd0, 5'd0, 1'b0, 3'b011, 16'h8001, 5'd0); tick();
    check("lui", ALU_DB, 32'h8001_0000);
    issue(5'd0, 5'd0, 1'b0, 3'b100, 16'h8001, 5'd31); tick(); idle();
    check("shamt", ALU_DB, 32'h0000_001F);

    // reset while stalled
    issue(5'd5, 5'd0, 1'b0, 3'b000, 16'd0, 5'd0); out_ready = 1'b0; tick();
    rst_n = 1'b0; tick(); idle();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    issue(5'd5, 5'd0, 1'b0, 3'b000, 16'd0, 5'd0); tick(); idle();
    check("mid_rst_r5", ALU_DA, 32'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      in_valid  = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      rs_addr   = 5'($urandom_range(0, 7));
      rt_addr   = 5'($urandom_range(0, 7));
      imm16     = 16'($urandom);
      shamt     = 5'($urandom);
      a_sel     = 1'($urandom);
      b_sel     = 3'($urandom);
      ctl_in    = 4'($urandom);
      wb_valid  = $urandom_range(0, 1) != 0;
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      wb_ovf    = $urandom_range(0, 5) == 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32, the data width of registers and operands.
REQ-002 The block SHALL expose parameter REG_N, default 32, the register count; address width is log2(REG_N) = 5.
REQ-003 The block SHALL use a single clock and a synchronous, active-low reset, with ports as follows.
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  decoded instruction offered
- in_ready  output  1  stage can accept instruction
- rs_addr  input  5  source register A index
- rt_addr  input  5  source register B index
- imm16  input  16  instruction immediate
- shamt  input  5  instruction shift amount
- a_sel  input  1  0: rs value, 1: rt value (shifts)
- b_sel  input  3  000 rt, 001 sign-ext imm, 010 zero-ext imm, 011 imm<<16, 100 zero-ext shamt, 101 rs value (variable shifts); 110/111 reserved, yield 0
- ctl_in  input  4  ALU control code, passed through
- wb_valid  input  1  write-back request
- wb_addr  input  5  write-back register index
- wb_data  input  32  write-back value (ALU result)
- wb_ovf  input  1  ALU overflow flag for this write-back
- ALU_DA  output  32  registered operand A
- ALU_DB  output  32  registered operand B
- ALU_CTL  output  4  registered ALU control
- out_valid  output  1  operands valid for the ALU
- out_ready  input  1  ALU stage consumes operands

Function
REQ-004 The register file SHALL hold REG_N x DATA_W entries; register 0 SHALL always read 0 and ignore writes.
REQ-005 A write SHALL commit on the rising edge when wb_valid=1, wb_addr!=0 and wb_ovf=0; when wb_ovf=1 the write SHALL be suppressed.
REQ-006 A same-cycle write SHALL be forwarded: a read of the committing address SHALL return wb_data in that cycle.
REQ-007 The output register SHALL have two states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-008 The block SHALL drive in_ready = !out_valid | out_ready (combinational).
REQ-009 A handshake in_valid & in_ready SHALL capture ALU_DA, ALU_DB and ALU_CTL and set out_valid on the next edge, giving a latency of 1 cycle.
REQ-010 Transitions: EMPTY -> FULL on capture; FULL -> EMPTY on out_ready with no capture; FULL -> FULL with new data on simultaneous out_ready and capture.
REQ-011 While FULL with out_ready=0, the outputs SHALL hold stable and in_ready SHALL be 0.
REQ-012 Captured operands SHALL NOT be updated by later write-backs; staleness is the issuer's responsibility.
REQ-013 Operand A SHALL be forwarded rs when a_sel=0 and forwarded rt when a_sel=1.
REQ-014 Operand B SHALL follow the b_sel encoding above.
REQ-015 Sign extension SHALL replicate imm16[15]; zero extension SHALL pad with 0.
REQ-016 Write-back SHALL operate independently of the handshake state, including while stalled.

Reset
REQ-017 While rst_n=0 at a clock edge, out_valid, ALU_DA, ALU_DB, ALU_CTL and all registers SHALL clear to 0, and no write SHALL commit.
REQ-018 Reset SHALL discard any held instruction; after rst_n rises, in_ready SHALL be 1.

Structure
REQ-019 The b_sel encodings, DATA_W and REG_N SHALL live in the shared CPU package alongside the ALU_CTL codes.
REQ-020 The register file SHALL be one sub-module, regfile_2r1w, containing the forwarding logic; operand muxing and the output register SHALL live in operand_fetch.

Verification
REQ-021 Write then read: wb r5=0x0000_1234, then issue rs=5, a_sel=0, b_sel=001, imm16=0xFFFE -> ALU_DA=0x0000_1234, ALU_DB=0xFFFF_FFFE, out_valid 1 cycle after the handshake.
REQ-022 r0 and overflow: wb r0=0xDEAD_BEEF, and wb r7=0x8000_0000 with wb_ovf=1 -> reads of r0 and r7 both return 0.
REQ-023 Forwarding: wb r3=0x55 in the same cycle as a capture with rt=3, b_sel=000 -> ALU_DB=0x55.
REQ-024 Backpressure: out_ready=0 for 3 cycles while FULL -> in_ready=0 and outputs unchanged; out_ready=1 with in_valid=1 -> new data the next cycle, no bubble.
REQ-025 Immediates: imm16=0x8001 with b_sel 010 -> 0x0000_8001; with 011 -> 0x8001_0000; shamt=31 with 100 -> 0x1F.
REQ-026 Reset mid-stall: rst_n=0 while FULL -> out_valid=0 and r5 reads 0 after release.
